// File: rtl/radix4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_pkg
//  Description : Items shared by the radix-4 Booth recoder and its digit
//                decoder. Contains the FSM state codes, the digit code
//                constants, the digits-per-frame helper and the legal-digit
//                check.
//  Revision    : 1.0 - initial release
// ============================================================================
package radix4_pkg;

  // Decoder FSM state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Signed 3-bit two's-complement digit codes
  localparam logic [2:0] D_M2 = 3'b110;
  localparam logic [2:0] D_M1 = 3'b111;
  localparam logic [2:0] D_0  = 3'b000;
  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_P2 = 3'b010;

  // Radix-4 digits needed to cover a width-bit signed operand
  function automatic int n_digits(input int width);
    return (width + 1) / 2;
  endfunction

  // Only -2..+2 are legal; +3, -4 and -3 are not
  function automatic logic digit_legal(input logic [2:0] code);
    return !((code == 3'b011) || (code == 3'b100) || (code == 3'b101));
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_digit_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_digit_decoder_if
//  Description : Digit stream and result bundle of the radix-4 digit decoder.
//    in_valid   source -> decoder  a digit is presented
//    in_first   source -> decoder  presented digit is digit 0 of a frame
//    in_digit   source -> decoder  signed 3-bit digit
//    in_ready   decoder -> source  decoder accepts a digit
//    y_out      decoder -> sink    reconstructed operand (Y_WIDTH bits)
//    out_valid  decoder -> sink    one-cycle completion pulse
//    out_err    decoder -> sink    illegal digit / protocol error in frame
//    out_ovf    decoder -> sink    value does not fit Y_WIDTH signed
//  master = digit source / result consumer, slave = decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface radix4_digit_decoder_if #(
  parameter int Y_WIDTH = 8
);
  logic               in_valid;
  logic               in_first;
  logic [2:0]         in_digit;
  logic               in_ready;
  logic [Y_WIDTH-1:0] y_out;
  logic               out_valid;
  logic               out_err;
  logic               out_ovf;

  modport master (
    output in_valid, in_first, in_digit,
    input  in_ready, y_out, out_valid, out_err, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_digit,
    output in_ready, y_out, out_valid, out_err, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/radix4_digit_acc.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_digit_acc
//  Description : Signed accumulator of the digit decoder. Loads digit 0 or
//                adds a later digit weighted by 4^pos, and exposes the
//                post-update value and its Y_WIDTH overflow status
//                combinationally so the caller can register them on the
//                completing edge.
//    clk, rst  clock, asynchronous active-high reset
//    load      start a frame: acc = digit
//    add       acc += digit << (2*pos)
//    digit     legal (already sanitised) 3-bit signed digit
//    pos       index of the digit being added
//    y_next    low Y_WIDTH bits of the post-update accumulator
//    ovf_next  post-update accumulator outside Y_WIDTH signed range
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_digit_acc
  import radix4_pkg::*;
#(
  parameter int Y_WIDTH = 8,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               add,
  input  logic [2:0]         digit,
  input  logic [CNT_W-1:0]   pos,
  output logic [Y_WIDTH-1:0] y_next,
  output logic               ovf_next
);

  localparam int N_DIGITS = n_digits(Y_WIDTH);
  // Two guard bits above the largest weight keep every legal frame exact
  localparam int ACC_W    = 2 * N_DIGITS + 2;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (Y_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;  // -(2^(Y-1))

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] digit_ext;
  logic signed [ACC_W-1:0] term;

  assign digit_ext = {{(ACC_W-3){digit[2]}}, digit};
  assign term      = digit_ext <<< {pos, 1'b0};

  always_comb begin
    acc_next = acc;
    if (load) begin
      acc_next = digit_ext;
    end else if (add) begin
      acc_next = acc + term;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  assign y_next   = acc_next[Y_WIDTH-1:0];
  assign ovf_next = (acc_next > Y_MAX) || (acc_next < Y_MIN);

endmodule
`default_nettype wire

// File: rtl/radix4_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_digit_decoder
//  Description : Serial receiver for radix-4 Booth digits. Accepts one signed
//                digit per handshake, LSB digit first, rebuilds the Y_WIDTH
//                two's-complement operand and pulses out_valid one cycle after
//                the last digit, with illegal-digit and overflow flags.
//    clk   rising-edge clock
//    rst   asynchronous active-high reset
//    bus   radix4_digit_decoder_if.slave (digit stream in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_digit_decoder
  import radix4_pkg::*;
#(
  parameter int Y_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  radix4_digit_decoder_if.slave bus
);

  localparam int N_DIGITS = n_digits(Y_WIDTH);
  localparam int CNT_W    = $clog2(N_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               err;
  logic               err_next;
  logic               legal;
  logic [2:0]         digit_eff;
  logic               start;
  logic               add;
  logic               accept;
  logic               finish;
  logic [Y_WIDTH-1:0] y_next;
  logic               ovf_next;
  logic [Y_WIDTH-1:0] y_q;
  logic               err_q;
  logic               ovf_q;
  logic               ready;
  logic               valid;

  // Illegal codes contribute nothing to the value but taint the frame
  assign legal     = digit_legal(bus.in_digit);
  assign digit_eff = legal ? bus.in_digit : D_0;

  // in_first always (re)starts a frame, in any state; plain digits only
  // count while collecting, so strays in IDLE/DONE are dropped silently
  assign start      = bus.in_valid & bus.in_first;
  assign add        = bus.in_valid & ~bus.in_first & (state == COLLECT);
  assign accept     = start | add;
  assign count_next = start ? ONE : count + ONE;
  assign finish     = accept & (count_next == LAST);

  // A restart while collecting marks the new frame as erroneous
  always_comb begin
    err_next = err;
    if (start) begin
      err_next = (state == COLLECT) | ~legal;
    end else if (add) begin
      err_next = err | ~legal;
    end
  end

  radix4_digit_acc #(
    .Y_WIDTH (Y_WIDTH),
    .CNT_W   (CNT_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .add      (add),
    .digit    (digit_eff),
    .pos      (count),
    .y_next   (y_next),
    .ovf_next (ovf_next)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (finish)     state_next = DONE;
        else if (start) state_next = COLLECT;
      end
      COLLECT: begin
        if (finish)     state_next = DONE;
      end
      DONE: begin
        // in_first here starts the next frame without a bubble
        if (finish)     state_next = DONE;
        else if (start) state_next = COLLECT;
        else            state_next = IDLE;
      end
      default:          state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE, COLLECT: ready = 1'b1;
      DONE: begin
        ready = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
      y_q   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        count <= count_next;
        err   <= err_next;
      end
      if (finish) begin
        y_q   <= y_next;
        err_q <= err_next;
        ovf_q <= ovf_next;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.y_out     = y_q;
  assign bus.out_err   = err_q;
  assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_radix4_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix4_digit_decoder
//  Description : Directed bench for radix4_digit_decoder at Y_WIDTH 8 and 7,
//                plus model-checked random legal streams at Y_WIDTH 2 and 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_digit_decoder;
  import radix4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses8  = 0;
  int last_p8  = 0;
  int prev_p8  = 0;

  radix4_digit_decoder_if #(.Y_WIDTH(8))  b8();
  radix4_digit_decoder_if #(.Y_WIDTH(7))  b7();
  radix4_digit_decoder_if #(.Y_WIDTH(2))  b2();
  radix4_digit_decoder_if #(.Y_WIDTH(16)) b16();

  radix4_digit_decoder #(.Y_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  radix4_digit_decoder #(.Y_WIDTH(7))  dut7  (.clk(clk), .rst(rst), .bus(b7));
  radix4_digit_decoder #(.Y_WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));
  radix4_digit_decoder #(.Y_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  always @(posedge clk) cyc <= cyc + 1;

  // Count out_valid pulses of the 8-bit decoder and remember when they came
  always @(negedge clk) begin
    if (b8.out_valid === 1'b1) begin
      pulses8 <= pulses8 + 1;
      prev_p8 <= last_p8;
      last_p8 <= cyc;
    end
  end

  function automatic logic [11:0] pack4(input logic [2:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic drive8(input logic v, input logic f, input logic [2:0] d);
    b8.in_valid = v; b8.in_first = f; b8.in_digit = d;
    @(posedge clk); #1;
    b8.in_valid = 1'b0; b8.in_first = 1'b0; b8.in_digit = 3'b000;
  endtask

  task automatic send_frame8(input logic [11:0] ds);
    for (int i = 0; i < 4; i++) drive8(1'b1, i == 0, ds[3*i +: 3]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b8.y_out !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", b8.y_out); end
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b8.out_valid); end
    n_checks++; if (b8.out_err !== 1'b0 || b8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got err=%b ovf=%b want 0 0", b8.out_err, b8.out_ovf); end
    n_checks++; if (b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", b8.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive8(1'b1, 1'b0, D_P2);  // stray digit in IDLE is ignored
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid: got %b want 0", b8.out_valid); end
    send_frame8(pack4(D_M2, D_M1, D_P2, D_P1));  // -2 -4 +32 +64 = 90
    n_checks++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", b8.out_valid); end
    n_checks++; if (b8.y_out !== 8'h5A) begin n_fail++; $display("FAIL basic_y: got %h want 5a", b8.y_out); end
    n_checks++; if (b8.out_err !== 1'b0 || b8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got err=%b ovf=%b want 0 0", b8.out_err, b8.out_ovf); end
    drive8(1'b0, 1'b0, D_0);
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_end: got %b want 0", b8.out_valid); end
    n_checks++; if (b8.y_out !== 8'h5A) begin n_fail++; $display("FAIL basic_hold: got %h want 5a", b8.y_out); end
  endtask

  task automatic test_boundary();
    send_frame8(pack4(D_0, D_0, D_0, D_M2));  // -2*64 = -128
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h80) begin n_fail++; $display("FAIL min_y: got v=%b y=%h want 1 80", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL min_ovf: got %b want 0", b8.out_ovf); end
    drive8(1'b0, 1'b0, D_0);
    send_frame8(pack4(D_P2, D_P2, D_P2, D_P2));  // 2+8+32+128 = 170
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'hAA) begin n_fail++; $display("FAIL max_y: got v=%b y=%h want 1 aa", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_ovf !== 1'b1 || b8.out_err !== 1'b0) begin n_fail++; $display("FAIL max_flags: got ovf=%b err=%b want 1 0", b8.out_ovf, b8.out_err); end
    drive8(1'b0, 1'b0, D_0);
  endtask

  task automatic test_illegal();
    send_frame8(pack4(D_P1, 3'b011, D_0, D_0));
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h01) begin n_fail++; $display("FAIL illegal_y: got v=%b y=%h want 1 01", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_err !== 1'b1 || b8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL illegal_flags: got err=%b ovf=%b want 1 0", b8.out_err, b8.out_ovf); end
    drive8(1'b1, 1'b0, D_P2);  // non-first digit in DONE: dropped
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL done_drop_valid: got %b want 0", b8.out_valid); end
    send_frame8(pack4(D_P1, D_0, D_0, D_0));
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h01) begin n_fail++; $display("FAIL clean_y: got v=%b y=%h want 1 01", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_err !== 1'b0) begin n_fail++; $display("FAIL clean_err: got %b want 0", b8.out_err); end
    drive8(1'b0, 1'b0, D_0);
  endtask

  task automatic test_restart();
    int p0;
    p0 = pulses8;
    drive8(1'b1, 1'b1, D_P1);
    drive8(1'b1, 1'b0, D_P1);
    send_frame8(pack4(D_P2, D_0, D_0, D_0));
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h02) begin n_fail++; $display("FAIL restart_y: got v=%b y=%h want 1 02", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_err !== 1'b1) begin n_fail++; $display("FAIL restart_err: got %b want 1", b8.out_err); end
    drive8(1'b0, 1'b0, D_0);
    drive8(1'b0, 1'b0, D_0);
    n_checks++; if (pulses8 - p0 !== 1) begin n_fail++; $display("FAIL restart_pulses: got %0d want 1", pulses8 - p0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses8;
    send_frame8(pack4(D_M2, D_M1, D_P2, D_P1));
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h5A) begin n_fail++; $display("FAIL b2b_first: got v=%b y=%h want 1 5a", b8.out_valid, b8.y_out); end
    send_frame8(pack4(D_0, D_0, D_0, D_M2));  // digit 0 lands in the DONE cycle
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h80) begin n_fail++; $display("FAIL b2b_second: got v=%b y=%h want 1 80", b8.out_valid, b8.y_out); end
    n_checks++; if (b8.out_err !== 1'b0 || b8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: got err=%b ovf=%b want 0 0", b8.out_err, b8.out_ovf); end
    drive8(1'b0, 1'b0, D_0);
    drive8(1'b0, 1'b0, D_0);
    n_checks++; if (pulses8 - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses8 - p0); end
    // 5 cycles first digit..out_valid inclusive, overlapped by one: period 4
    n_checks++; if (last_p8 - prev_p8 !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", last_p8 - prev_p8); end
  endtask

  task automatic test_reset_midframe();
    int p0;
    drive8(1'b1, 1'b1, D_P1);
    drive8(1'b1, 1'b0, D_P1);
    rst = 1'b1;
    #1;
    n_checks++; if (b8.y_out !== 8'h00 || b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got v=%b y=%h want 0 00", b8.out_valid, b8.y_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pulses8;
    send_frame8(pack4(D_M2, D_M1, D_P2, D_P1));
    n_checks++; if (b8.out_valid !== 1'b1 || b8.y_out !== 8'h5A || b8.out_err !== 1'b0) begin n_fail++; $display("FAIL midrst_next: got v=%b y=%h err=%b want 1 5a 0", b8.out_valid, b8.y_out, b8.out_err); end
    drive8(1'b0, 1'b0, D_0);
    drive8(1'b0, 1'b0, D_0);
    n_checks++; if (pulses8 - p0 !== 1) begin n_fail++; $display("FAIL midrst_pulses: got %0d want 1", pulses8 - p0); end
  endtask

  task automatic test_width7();
    logic [11:0] ds;
    ds = pack4(D_M1, D_0, D_0, D_P1);  // -1 + 64 = 63
    for (int i = 0; i < 4; i++) begin
      b7.in_valid = 1'b1; b7.in_first = (i == 0); b7.in_digit = ds[3*i +: 3];
      @(posedge clk); #1;
    end
    b7.in_valid = 1'b0; b7.in_first = 1'b0;
    n_checks++; if (b7.out_valid !== 1'b1 || b7.y_out !== 7'h3F) begin n_fail++; $display("FAIL w7_y: got v=%b y=%h want 1 3f", b7.out_valid, b7.y_out); end
    n_checks++; if (b7.out_ovf !== 1'b0 || b7.out_err !== 1'b0) begin n_fail++; $display("FAIL w7_flags: got ovf=%b err=%b want 0 0", b7.out_ovf, b7.out_err); end
    @(posedge clk); #1;
  endtask

  // Y_WIDTH=2 is a one-digit frame: every in_first completes immediately
  task automatic test_random_w2();
    int d;
    logic [1:0] y_exp;
    for (int k = 0; k < 12; k++) begin
      d = (k < 5) ? k - 2 : int'($urandom_range(0, 4)) - 2;
      y_exp = 2'(d);
      b2.in_valid = 1'b1; b2.in_first = 1'b1; b2.in_digit = 3'(d);
      @(posedge clk); #1;
      n_checks++; if (b2.out_valid !== 1'b1 || b2.y_out !== y_exp) begin n_fail++; $display("FAIL w2_y[%0d]: got v=%b y=%b want 1 %b", k, b2.out_valid, b2.y_out, y_exp); end
      n_checks++; if (b2.out_ovf !== (d == 2) || b2.out_err !== 1'b0) begin n_fail++; $display("FAIL w2_flags[%0d]: got ovf=%b err=%b want %b 0", k, b2.out_ovf, b2.out_err, d == 2); end
    end
    b2.in_valid = 1'b0; b2.in_first = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_w16();
    int d;
    int acc;
    logic [31:0] acc_bits;
    logic ovf_exp;
    for (int f = 0; f < 6; f++) begin
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        d = (f == 0) ? 2 : int'($urandom_range(0, 4)) - 2;
        acc = acc + d * (1 << (2 * i));
        if (i > 0 && $urandom_range(0, 2) == 0) begin
          b16.in_valid = 1'b0;
          repeat (int'($urandom_range(1, 3))) begin @(posedge clk); #1; end
        end
        b16.in_valid = 1'b1; b16.in_first = (i == 0); b16.in_digit = 3'(d);
        @(posedge clk); #1;
      end
      b16.in_valid = 1'b0; b16.in_first = 1'b0;
      acc_bits = acc;
      ovf_exp = (acc > 32767) || (acc < -32768);
      n_checks++; if (b16.out_valid !== 1'b1 || b16.y_out !== acc_bits[15:0]) begin n_fail++; $display("FAIL w16_y[%0d]: got v=%b y=%h want 1 %h", f, b16.out_valid, b16.y_out, acc_bits[15:0]); end
      n_checks++; if (b16.out_ovf !== ovf_exp || b16.out_err !== 1'b0) begin n_fail++; $display("FAIL w16_flags[%0d]: got ovf=%b err=%b want %b 0", f, b16.out_ovf, b16.out_err, ovf_exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    b8.in_valid  = 1'b0; b8.in_first  = 1'b0; b8.in_digit  = 3'b000;
    b7.in_valid  = 1'b0; b7.in_first  = 1'b0; b7.in_digit  = 3'b000;
    b2.in_valid  = 1'b0; b2.in_first  = 1'b0; b2.in_digit  = 3'b000;
    b16.in_valid = 1'b0; b16.in_first = 1'b0; b16.in_digit = 3'b000;
    test_reset();
    test_basic();
    test_boundary();
    test_illegal();
    test_restart();
    test_back_to_back();
    test_reset_midframe();
    test_width7();
    test_random_w2();
    test_random_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
